fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a registered PC/instruction output.
// Per-edge priority is reset > redirect > stall > advance.
// After a redirect the FSM spends FLUSH_CYCLES cycles in FLUSH before it fetches again.
// Optional macro FETCH_PERF_CNT_EN builds the saturating fetch and stall counters.
// Without the macro, both counter outputs are tied to zero.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk_cpu,
  input  logic        rst_i,
  input  logic        pipline_stop_i,
  input  logic        have_inst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] irom_inst_i,
  output logic [13:0] irom_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [1:0]  state_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_q, inst_d;
  logic        vld_q, vld_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] redirect_tgt;

  // The low two bits of the redirect target are dropped because fetch is word aligned.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];
  assign redirect_tgt        = {redirect_pc_i[31:2], 2'b00};

  // Next-state logic: the FSM, fetch PC, output registers and flush countdown.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_out_d    = pc_out_q;
    inst_d      = inst_q;
    vld_d       = 1'b0;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_BOOT: begin
        // BOOT always lasts exactly one cycle. A redirect seen here is still taken.
        if (redirect_i) begin
          pc_d        = redirect_tgt;
          flush_cnt_d = FLUSH_LOAD;
          state_d     = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (redirect_i) begin
          pc_d        = redirect_tgt;
          flush_cnt_d = FLUSH_LOAD;
          state_d     = ST_FLUSH;
        end else if (pipline_stop_i) begin
          state_d = ST_HOLD;
        end else begin
          inst_d   = irom_inst_i;
          pc_out_d = pc_q;
          vld_d    = have_inst_i;
          pc_d     = pc_q + 32'd4;
          state_d  = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (redirect_i) begin
          pc_d        = redirect_tgt;
          flush_cnt_d = FLUSH_LOAD;
        end else if (!pipline_stop_i) begin
          // The last bubble cycle hands over to RUN, which fetches on the following edge.
          if (flush_cnt_q <= 4'd1) begin
            flush_cnt_d = 4'd0;
            state_d     = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // State registers. The async reset also forces the data outputs to their reset values.
  always_ff @(posedge clk_cpu or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      pc_out_q    <= RESET_PC;
      inst_q      <= NOP_INST;
      vld_q       <= 1'b0;
      flush_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_out_q    <= pc_out_d;
      inst_q      <= inst_d;
      vld_q       <= vld_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign irom_addr_o  = pc_q[15:2];
  assign pc_o         = pc_out_q;
  assign pc4_o        = pc_out_q + 32'd4;
  assign inst_o       = inst_q;
  assign inst_valid_o = vld_q;
  assign state_o      = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters for delivered instructions and stall-request cycles.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (vld_d && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (pipline_stop_i && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk_cpu or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign fetch_cnt_o = 32'd0;
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with FLUSH_CYCLES=2 and ROM[i]=i.
module tb_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_cpu = 1'b0;
  logic        rst_i = 1'b1;
  logic        pipline_stop_i = 1'b0;
  logic        have_inst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic [31:0] irom_inst_i;
  logic [13:0] irom_addr_o;
  logic [31:0] pc_o, pc4_o, inst_o, fetch_cnt_o, stall_cnt_o;
  logic        inst_valid_o;
  logic [1:0]  state_o;

  int n_pass = 0;
  int n_total = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
    .clk_cpu       (clk_cpu),
    .rst_i         (rst_i),
    .pipline_stop_i(pipline_stop_i),
    .have_inst_i   (have_inst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .irom_inst_i   (irom_inst_i),
    .irom_addr_o   (irom_addr_o),
    .pc_o          (pc_o),
    .pc4_o         (pc4_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o),
    .state_o       (state_o),
    .fetch_cnt_o   (fetch_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  // ROM model: word i holds the value i
  assign irom_inst_i = {18'd0, irom_addr_o};

  always #5 clk_cpu = ~clk_cpu;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st, input logic vld,
                         input logic [31:0] pc, input logic [31:0] inst, input logic [13:0] addr);
    chk({tag, ".state"}, {30'd0, state_o}, {30'd0, st});
    chk({tag, ".vld"},   {31'd0, inst_valid_o}, {31'd0, vld});
    chk({tag, ".pc"},    pc_o, pc);
    chk({tag, ".pc4"},   pc4_o, pc + 32'd4);
    chk({tag, ".inst"},  inst_o, inst);
    chk({tag, ".addr"},  {18'd0, irom_addr_o}, {18'd0, addr});
  endtask

  task automatic chk_reset(input string tag);
    chk_out(tag, 2'd0, 1'b0, 32'd0, 32'h13, 14'd0);
    chk({tag, ".fcnt"}, fetch_cnt_o, 32'd0);
    chk({tag, ".scnt"}, stall_cnt_o, 32'd0);
  endtask

  initial begin
    // Reset held across edges
    step();
    step();
    chk_reset("rst_hold");
    rst_i = 1'b0;

    // Boot then sequential fetch
    step(); chk_out("boot",  2'd1, 1'b0, 32'd0,  32'h13, 14'd1 - 14'd1);
    step(); chk_out("f0",    2'd1, 1'b1, 32'd0,  32'd0, 14'd1);
    step(); chk_out("f1",    2'd1, 1'b1, 32'd4,  32'd1, 14'd2);
    step(); chk_out("f2",    2'd1, 1'b1, 32'd8,  32'd2, 14'd3);
    step(); chk_out("f3",    2'd1, 1'b1, 32'hC,  32'd3, 14'd4);

    // Three stall cycles at pc_q=0x10
    pipline_stop_i = 1'b1;
    step(); chk_out("st1",   2'd2, 1'b0, 32'hC,  32'd3, 14'd4);
    step(); chk_out("st2",   2'd2, 1'b0, 32'hC,  32'd3, 14'd4);
    step(); chk_out("st3",   2'd2, 1'b0, 32'hC,  32'd3, 14'd4);
    chk("stall_cnt3", stall_cnt_o, PERF ? 32'd3 : 32'd0);
    chk("fetch_cnt4", fetch_cnt_o, PERF ? 32'd4 : 32'd0);
    pipline_stop_i = 1'b0;
    step(); chk_out("resume", 2'd1, 1'b1, 32'h10, 32'd4, 14'd5);

    // Redirect to 0x43 with two flush cycles; the low bits are dropped
    redirect_i = 1'b1; redirect_pc_i = 32'h43;
    step(); chk_out("rd0",   2'd3, 1'b0, 32'h10, 32'd4, 14'h10);
    redirect_i = 1'b0;
    step(); chk_out("rd1",   2'd3, 1'b0, 32'h10, 32'd4, 14'h10);
    step(); chk_out("rd2",   2'd1, 1'b0, 32'h10, 32'd4, 14'h10);
    step(); chk_out("rd3",   2'd1, 1'b1, 32'h40, 32'h10, 14'h11);

    // Redirect and stall together: redirect wins, flush count is frozen while stalled
    redirect_i = 1'b1; redirect_pc_i = 32'h100; pipline_stop_i = 1'b1;
    step(); chk_out("rs0",   2'd3, 1'b0, 32'h40, 32'h10, 14'h40);
    redirect_i = 1'b0;
    step(); chk_out("rs1",   2'd3, 1'b0, 32'h40, 32'h10, 14'h40);
    pipline_stop_i = 1'b0;
    step(); chk_out("rs2",   2'd3, 1'b0, 32'h40, 32'h10, 14'h40);
    step(); chk_out("rs3",   2'd1, 1'b0, 32'h40, 32'h10, 14'h40);
    step(); chk_out("rs4",   2'd1, 1'b1, 32'h100, 32'h40, 14'h41);
    chk("stall_cnt5", stall_cnt_o, PERF ? 32'd5 : 32'd0);
    chk("fetch_cnt7", fetch_cnt_o, PERF ? 32'd7 : 32'd0);

    // Squashed slot: the PC advances but the output is not valid
    have_inst_i = 1'b0;
    step(); chk_out("sq",    2'd1, 1'b0, 32'h104, 32'h41, 14'h42);
    have_inst_i = 1'b1;

    // Wrap at the top of the address space
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    step(); chk_out("w0",    2'd3, 1'b0, 32'h104, 32'h41, 14'h3FFF);
    redirect_i = 1'b0;
    step();
    step(); chk_out("w2",    2'd1, 1'b0, 32'h104, 32'h41, 14'h3FFF);
    step(); chk_out("w3",    2'd1, 1'b1, 32'hFFFF_FFFC, 32'h3FFF, 14'd0);
    step(); chk_out("w4",    2'd1, 1'b1, 32'd0, 32'd0, 14'd1);
    chk("fetch_cnt9", fetch_cnt_o, PERF ? 32'd9 : 32'd0);

    // Reset pulse in the middle of FLUSH takes effect without a clock edge
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    step(); chk_out("mf",    2'd3, 1'b0, 32'd0, 32'd0, 14'h80);
    redirect_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk_reset("rst_async");
    step();
    chk_reset("rst_edge");
    rst_i = 1'b0;

    // Redirect during BOOT: BOOT still lasts one cycle, then FLUSH
    redirect_i = 1'b1; redirect_pc_i = 32'h80;
    step(); chk_out("bt0",   2'd3, 1'b0, 32'd0, 32'h13, 14'h20);
    redirect_i = 1'b0;
    step();
    step(); chk_out("bt2",   2'd1, 1'b0, 32'd0, 32'h13, 14'h20);
    step(); chk_out("bt3",   2'd1, 1'b1, 32'h80, 32'h20, 14'h21);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
